// File: rtl/subleq_sequencer_if.sv
// Shared memory port of the SUBLEQ sequencer: one request at a time, completed by memAck.
interface subleq_sequencer_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] memAddr;
  logic             memRdEn;
  logic             memWrEn;
  logic [WIDTH-1:0] memWData;
  logic [WIDTH-1:0] memRData;
  logic             memAck;

  modport master (
    output memAddr, memRdEn, memWrEn, memWData,
    input  memRData, memAck
  );

  modport slave (
    input  memAddr, memRdEn, memWrEn, memWData,
    output memRData, memAck
  );
endinterface

// File: rtl/subleq_sequencer.sv
// SUBLEQ instruction sequencer driving a single req/ack memory port.
// Optional 32-bit retired-instruction counter: define SUBLEQ_SEQ_INSTR_COUNT_EN.
module subleq_sequencer #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}}
) (
  input  logic               clkIn,
  input  logic               reset,
  input  logic               start,
  subleq_sequencer_if.master mem,
  output logic [WIDTH-1:0]   pc,
  output logic               busy,
  output logic               halted
`ifdef SUBLEQ_SEQ_INSTR_COUNT_EN
  ,
  output logic [31:0]        instrCount
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH_A = 3'd1,
    ST_FETCH_B = 3'd2,
    ST_FETCH_C = 3'd3,
    ST_LOAD_A  = 3'd4,
    ST_LOAD_B  = 3'd5,
    ST_WRITE   = 3'd6,
    ST_HALT    = 3'd7
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] pc_r, pc_s;
  logic [WIDTH-1:0] a_r, a_s, b_r, b_s, c_r, c_s;
  logic [WIDTH-1:0] opa_r, opa_s, opb_r, opb_s;
  logic [WIDTH-1:0] addr_r, addr_s, wdata_r, wdata_s;
  logic             rd_en_r, rd_en_s, wr_en_r, wr_en_s;
  logic             busy_r, busy_s, halted_r, halted_s;
  logic [WIDTH-1:0] diff_s;
  logic             taken_s;

  assign mem.memAddr  = addr_r;
  assign mem.memRdEn  = rd_en_r;
  assign mem.memWrEn  = wr_en_r;
  assign mem.memWData = wdata_r;
  assign pc           = pc_r;
  assign busy         = busy_r;
  assign halted       = halted_r;

  // State register plus every output, loaded from the next-state values so outputs track the state.
  always_ff @(posedge clkIn or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      pc_r     <= RESET_PC;
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      c_r      <= {WIDTH{1'b0}};
      opa_r    <= {WIDTH{1'b0}};
      opb_r    <= {WIDTH{1'b0}};
      addr_r   <= {WIDTH{1'b0}};
      wdata_r  <= {WIDTH{1'b0}};
      rd_en_r  <= 1'b0;
      wr_en_r  <= 1'b0;
      busy_r   <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      pc_r     <= pc_s;
      a_r      <= a_s;
      b_r      <= b_s;
      c_r      <= c_s;
      opa_r    <= opa_s;
      opb_r    <= opb_s;
      addr_r   <= addr_s;
      wdata_r  <= wdata_s;
      rd_en_r  <= rd_en_s;
      wr_en_r  <= wr_en_s;
      busy_r   <= busy_s;
      halted_r <= halted_s;
    end
  end

  // Next-state logic: the address/data of the next request is set up on the transition into its state.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    a_s     = a_r;
    b_s     = b_r;
    c_s     = c_r;
    opa_s   = opa_r;
    opb_s   = opb_r;
    addr_s  = addr_r;
    wdata_s = wdata_r;
    diff_s  = opb_r - opa_r;
    taken_s = diff_s[WIDTH-1] | (diff_s == {WIDTH{1'b0}});

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_FETCH_A;
          addr_s  = pc_r;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH_A: begin
        if (mem.memAck) begin
          a_s     = mem.memRData;
          state_s = ST_FETCH_B;
          addr_s  = pc_r + WIDTH'(1'b1);
        end else begin
          state_s = ST_FETCH_A;
        end
      end
      ST_FETCH_B: begin
        if (mem.memAck) begin
          b_s     = mem.memRData;
          state_s = ST_FETCH_C;
          addr_s  = pc_r + WIDTH'(2'd2);
        end else begin
          state_s = ST_FETCH_B;
        end
      end
      ST_FETCH_C: begin
        if (mem.memAck) begin
          c_s     = mem.memRData;
          state_s = ST_LOAD_A;
          addr_s  = a_r;
        end else begin
          state_s = ST_FETCH_C;
        end
      end
      ST_LOAD_A: begin
        if (mem.memAck) begin
          opa_s   = mem.memRData;
          state_s = ST_LOAD_B;
          addr_s  = b_r;
        end else begin
          state_s = ST_LOAD_A;
        end
      end
      ST_LOAD_B: begin
        if (mem.memAck) begin
          opb_s   = mem.memRData;
          state_s = ST_WRITE;
          addr_s  = b_r;
          wdata_s = mem.memRData - opa_r;
        end else begin
          state_s = ST_LOAD_B;
        end
      end
      ST_WRITE: begin
        if (mem.memAck) begin
          if (taken_s) begin
            // A taken branch onto itself can never make progress, so it is the halt idiom.
            if (c_r == pc_r) begin
              state_s = ST_HALT;
            end else begin
              state_s = ST_FETCH_A;
              pc_s    = c_r;
              addr_s  = c_r;
            end
          end else begin
            state_s = ST_FETCH_A;
            pc_s    = pc_r + WIDTH'(2'd3);
            addr_s  = pc_r + WIDTH'(2'd3);
          end
        end else begin
          state_s = ST_WRITE;
        end
      end
      ST_HALT: begin
        if (start) begin
          state_s = ST_FETCH_A;
          pc_s    = RESET_PC;
          addr_s  = RESET_PC;
        end else begin
          state_s = ST_HALT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    rd_en_s  = (state_s == ST_FETCH_A) || (state_s == ST_FETCH_B) || (state_s == ST_FETCH_C) ||
               (state_s == ST_LOAD_A)  || (state_s == ST_LOAD_B);
    wr_en_s  = (state_s == ST_WRITE);
    busy_s   = (state_s != ST_IDLE) && (state_s != ST_HALT);
    halted_s = (state_s == ST_HALT);
  end

`ifdef SUBLEQ_SEQ_INSTR_COUNT_EN
  logic [31:0] cnt_r;

  // Retired-instruction counter: one per completed write-back, restarted along with the program.
  always_ff @(posedge clkIn or posedge reset) begin
    if (reset) begin
      cnt_r <= 32'd0;
    end else if ((state_r == ST_HALT) && start) begin
      cnt_r <= 32'd0;
    end else if ((state_r == ST_WRITE) && mem.memAck) begin
      cnt_r <= cnt_r + 32'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign instrCount = cnt_r;
`else
  // Instruction counter not built in this configuration.
`endif

endmodule

// File: tb/tb_subleq_sequencer.sv
// Randomized self-checking bench for subleq_sequencer: memory slave with wait states plus an
// instruction-level SUBLEQ reference model predicting every memory access and the final state.
module tb_subleq_sequencer;

  typedef struct packed {
    logic [15:0] addr;
    logic        wr;
    logic [15:0] data;
  } acc_t;

  logic        clkIn = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] pc;
  logic        busy;
  logic        halted;
`ifdef SUBLEQ_SEQ_INSTR_COUNT_EN
  logic [31:0] instrCount;
`endif

  subleq_sequencer_if #(.WIDTH(16)) mem_if ();

  subleq_sequencer #(.WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clkIn      (clkIn),
    .reset      (reset),
    .start      (start),
    .mem        (mem_if),
    .pc         (pc),
    .busy       (busy),
    .halted     (halted)
`ifdef SUBLEQ_SEQ_INSTR_COUNT_EN
    ,
    .instrCount (instrCount)
`endif
  );

  always #5 clkIn = ~clkIn;

  logic [15:0] mem     [0:65535];
  logic [15:0] ref_mem [0:65535];
  acc_t        got_q[$];
  acc_t        exp_q[$];
  logic [15:0] ref_pc;
  bit          ref_halt;
  int          ref_cnt;

  int          checks = 0;
  int          errors = 0;
  int          wait_n = 0;
  int          ack_limit = 1 << 30;
  int          acks_given = 0;
  int          wcnt = 0;
  int          viol = 0;
  bit          wr_seen = 1'b0;
  bit          pend = 1'b0;
  acc_t        lat;
  logic [15:0] p_addr, p_wdata;
  logic        p_rd, p_wr;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory slave: acks after wait_n idle cycles, logs each completed access, commits writes.
  always @(negedge clkIn) begin
    if (reset) begin
      mem_if.memAck = 1'b0;
      wcnt = 0;
      pend = 1'b0;
    end else begin
      if (mem_if.memAck) begin
        got_q.push_back(lat);
        if (lat.wr) mem[lat.addr] = lat.data;
        mem_if.memAck = 1'b0;
        wcnt = 0;
      end else if (pend) begin
        if (mem_if.memAddr !== p_addr || mem_if.memRdEn !== p_rd ||
            mem_if.memWrEn !== p_wr || mem_if.memWData !== p_wdata) viol++;
      end
      if (mem_if.memRdEn && mem_if.memWrEn) viol++;
      if (mem_if.memWrEn) wr_seen = 1'b1;
      pend = 1'b0;
      if (mem_if.memRdEn || mem_if.memWrEn) begin
        if (wcnt >= wait_n && acks_given < ack_limit) begin
          mem_if.memAck   = 1'b1;
          mem_if.memRData = mem[mem_if.memAddr];
          lat.addr = mem_if.memAddr;
          lat.wr   = mem_if.memWrEn;
          lat.data = mem_if.memWrEn ? mem_if.memWData : 16'h0000;
          acks_given++;
        end else begin
          wcnt++;
          pend    = 1'b1;
          p_addr  = mem_if.memAddr;
          p_rd    = mem_if.memRdEn;
          p_wr    = mem_if.memWrEn;
          p_wdata = mem_if.memWData;
        end
      end
    end
  end

  function automatic acc_t mk(input logic [15:0] addr, input logic wr, input logic [15:0] data);
    acc_t r;
    r.addr = addr;
    r.wr   = wr;
    r.data = data;
    return r;
  endfunction

  // One SUBLEQ instruction at the architectural level.
  function automatic void model_step();
    logic [15:0] p1, p2, a, b, c, d;
    p1 = ref_pc + 16'd1;
    p2 = ref_pc + 16'd2;
    a  = ref_mem[ref_pc];
    b  = ref_mem[p1];
    c  = ref_mem[p2];
    d  = ref_mem[b] - ref_mem[a];
    exp_q.push_back(mk(ref_pc, 1'b0, 16'h0000));
    exp_q.push_back(mk(p1, 1'b0, 16'h0000));
    exp_q.push_back(mk(p2, 1'b0, 16'h0000));
    exp_q.push_back(mk(a, 1'b0, 16'h0000));
    exp_q.push_back(mk(b, 1'b0, 16'h0000));
    exp_q.push_back(mk(b, 1'b1, d));
    ref_mem[b] = d;
    ref_cnt++;
    if ($signed(d) <= 0) begin
      if (c == ref_pc) ref_halt = 1'b1;
      else ref_pc = c;
    end else begin
      ref_pc = ref_pc + 16'd3;
    end
  endfunction

  task automatic poke(input logic [15:0] addr, input logic [15:0] val);
    mem[addr]     = val;
    ref_mem[addr] = val;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clkIn);
    #1;
    reset      = 1'b0;
    got_q.delete();
    acks_given = 0;
    ack_limit  = 1 << 30;
    ref_halt   = 1'b0;
  endtask

  // Runs up to n instructions (optionally after a start pulse) and compares against the model.
  task automatic run_prog(input string tag, input int n, input int w, input bit do_start);
    int cyc;
    int target;
    wait_n = w;
    exp_q.delete();
    got_q.delete();
    if (do_start) begin
      ref_pc   = 16'h0000;
      ref_halt = 1'b0;
      ref_cnt  = 0;
    end
    for (int i = 0; i < n && !ref_halt; i++) model_step();
    target = exp_q.size();
    if (do_start) begin
      @(negedge clkIn);
      start = 1'b1;
      @(negedge clkIn);
      #1;
      start = 1'b0;
    end
    cyc = 0;
    while (got_q.size() < target && cyc < 4000) begin
      @(negedge clkIn);
      #1;
      cyc++;
    end
    check_eq({tag, "_n_acc"}, 64'(got_q.size()), 64'(target));
    check_eq({tag, "_cycles"}, 64'(cyc), 64'(target * (w + 1)));
    for (int i = 0; i < target && i < got_q.size(); i++)
      check_eq($sformatf("%s_acc%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    for (int i = 0; i < target; i++)
      if (exp_q[i].wr) check_eq({tag, "_memwr"}, 64'(mem[exp_q[i].addr]), 64'(ref_mem[exp_q[i].addr]));
    check_eq({tag, "_pc"}, 64'(pc), 64'(ref_pc));
    check_eq({tag, "_halted"}, 64'(halted), 64'(ref_halt));
    check_eq({tag, "_busy"}, 64'(busy), 64'(!ref_halt));
`ifdef SUBLEQ_SEQ_INSTR_COUNT_EN
    check_eq({tag, "_count"}, 64'(instrCount), 64'(ref_cnt));
`endif
  endtask

  task automatic load_taken_prog();
    poke(16'd0, 16'd3); poke(16'd1, 16'd4); poke(16'd2, 16'd6);
    poke(16'd3, 16'd5); poke(16'd4, 16'd2);
    poke(16'd6, 16'd9); poke(16'd7, 16'd9); poke(16'd8, 16'd6);
    poke(16'd9, 16'h1234);
  endtask

  initial begin
    mem_if.memAck   = 1'b0;
    mem_if.memRData = 16'h0000;
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 16'h0000;
      ref_mem[i] = 16'h0000;
    end

    // Reset state
    do_reset();
    check_eq("rst_pc", 64'(pc), 64'h0);
    check_eq("rst_busy", 64'(busy), 64'h0);
    check_eq("rst_halted", 64'(halted), 64'h0);
    check_eq("rst_rden", 64'(mem_if.memRdEn), 64'h0);
    check_eq("rst_wren", 64'(mem_if.memWrEn), 64'h0);
    check_eq("rst_addr", 64'(mem_if.memAddr), 64'h0);
    check_eq("rst_wdata", 64'(mem_if.memWData), 64'h0);
`ifdef SUBLEQ_SEQ_INSTR_COUNT_EN
    check_eq("rst_count", 64'(instrCount), 64'h0);
`endif

    // Taken branch, then self-loop halt, then restart from HALT
    load_taken_prog();
    run_prog("taken", 1, 0, 1'b1);
    check_eq("taken_mem4", 64'(mem[4]), 64'hFFFD);
    check_eq("taken_pc6", 64'(pc), 64'h6);
    run_prog("halt", 1, 0, 1'b0);
    check_eq("halt_mem9", 64'(mem[9]), 64'h0);
    check_eq("halt_flag", 64'(halted), 64'h1);
    run_prog("restart", 8, 0, 1'b1);
    check_eq("restart_first_addr", 64'(got_q.size() > 0 ? got_q[0].addr : 16'hDEAD), 64'h0);

    // Three wait states on every access
    do_reset();
    load_taken_prog();
    run_prog("wait3", 8, 3, 1'b1);

    // Not-taken branch
    do_reset();
    poke(16'd0, 16'd3); poke(16'd1, 16'd4); poke(16'd2, 16'd9);
    poke(16'd3, 16'd1); poke(16'd4, 16'd7);
    run_prog("nottaken", 1, 0, 1'b1);
    check_eq("nottaken_mem4", 64'(mem[4]), 64'h6);
    check_eq("nottaken_pc", 64'(pc), 64'h3);

    // Address wrap: branch to 0xFFFE, then a non-taken instruction there
    do_reset();
    poke(16'h0000, 16'h0100); poke(16'h0001, 16'h0100); poke(16'h0002, 16'hFFFE);
    poke(16'hFFFE, 16'h0101); poke(16'hFFFF, 16'h0102);
    poke(16'h0100, 16'h0077); poke(16'h0101, 16'h0001); poke(16'h0102, 16'h0005);
    run_prog("wrap", 2, 0, 1'b1);
    check_eq("wrap_pc", 64'(pc), 64'h1);
    check_eq("wrap_mem102", 64'(mem[16'h0102]), 64'h4);

    // Reset while LOAD_B is waiting for its ack
    do_reset();
    load_taken_prog();
    ack_limit = 4;
    wait_n    = 0;
    @(negedge clkIn);
    start = 1'b1;
    @(negedge clkIn);
    #1;
    start = 1'b0;
    wr_seen = 1'b0;
    repeat (20) begin
      @(negedge clkIn);
      #1;
    end
    check_eq("ldb_n_acc", 64'(got_q.size()), 64'h4);
    check_eq("ldb_rden", 64'(mem_if.memRdEn), 64'h1);
    check_eq("ldb_addr", 64'(mem_if.memAddr), 64'h4);
    #2 reset = 1'b1;
    #1;
    check_eq("rstmid_rden", 64'(mem_if.memRdEn), 64'h0);
    check_eq("rstmid_wren", 64'(mem_if.memWrEn), 64'h0);
    check_eq("rstmid_pc", 64'(pc), 64'h0);
    check_eq("rstmid_busy", 64'(busy), 64'h0);
    check_eq("rstmid_halted", 64'(halted), 64'h0);
`ifdef SUBLEQ_SEQ_INSTR_COUNT_EN
    check_eq("rstmid_count", 64'(instrCount), 64'h0);
`endif
    repeat (3) @(negedge clkIn);
    reset     = 1'b0;
    ack_limit = 1 << 30;
    repeat (5) begin
      @(negedge clkIn);
      #1;
    end
    check_eq("rstmid_no_write", 64'(wr_seen), 64'h0);
    check_eq("rstmid_idle", 64'(busy), 64'h0);
    check_eq("rstmid_mem4", 64'(mem[4]), 64'h2);

    // Random forward-branching programs ending in a self-loop halt
    for (int r = 0; r < 8; r++) begin
      int k;
      int w;
      do_reset();
      k = $urandom_range(2, 6);
      w = $urandom_range(0, 3);
      for (int j = 0; j < 16; j++) poke(16'h0200 + 16'(j), 16'($urandom_range(0, 65535)));
      for (int i = 0; i < k - 1; i++) begin
        poke(16'(3 * i),     16'h0200 + 16'($urandom_range(0, 15)));
        poke(16'(3 * i + 1), 16'h0200 + 16'($urandom_range(0, 15)));
        poke(16'(3 * i + 2), 16'(3 * $urandom_range(i + 1, k - 1)));
      end
      begin
        logic [15:0] h;
        h = 16'h0200 + 16'($urandom_range(0, 15));
        poke(16'(3 * (k - 1)),     h);
        poke(16'(3 * (k - 1) + 1), h);
        poke(16'(3 * (k - 1) + 2), 16'(3 * (k - 1)));
      end
      run_prog($sformatf("rand%0d", r), 64, w, 1'b1);
    end

    check_eq("handshake_stable", 64'(viol), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
